// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU dispatch slice.
// Opcodes, unit count, result width and dispatcher state encoding.
package alu_pkg;

  localparam int NUM_UNITS = 6;
  localparam int RES_W     = 32;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: opcode -> one-hot unit select + legal flag.
// Ports: opcode[4:0] in; onehot[5:0], legal out.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [4:0]           opcode,
  output logic [NUM_UNITS-1:0] onehot,
  output logic                 legal
);

  always_comb begin
    onehot = '0;
    legal  = 1'b1;
    case (opcode)
      OP_ADD:  onehot = 6'b000001;
      OP_SUB:  onehot = 6'b000010;
      OP_AND:  onehot = 6'b000100;
      OP_OR:   onehot = 6'b001000;
      OP_SLL:  onehot = 6'b010000;
      OP_SRA:  onehot = 6'b100000;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_dispatch.sv
// Issues one ALU request to one of six units, waits for done or timeout,
// and returns the captured result over a valid/ready response port.
// Ports: req_* request in, op_*/unit_start to units, unit_done/unit_result
// from units, rsp_* response out, busy = not idle.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [4:0]                 req_opcode,
  input  logic [31:0]                req_a,
  input  logic [31:0]                req_b,
  input  logic [4:0]                 req_shamt,
  output logic [31:0]                op_a,
  output logic [31:0]                op_b,
  output logic [4:0]                 op_shamt,
  output logic [NUM_UNITS-1:0]       unit_start,
  input  logic [NUM_UNITS-1:0]       unit_done,
  input  logic [NUM_UNITS*RES_W-1:0] unit_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_result,
  output logic                       rsp_error,
  output logic                       busy
);

  state_t               state, state_n;
  logic [NUM_UNITS-1:0] sel;
  logic [NUM_UNITS-1:0] dec_oh;
  logic                 dec_legal;
  logic [7:0]           cnt, cnt_n;
  logic [NUM_UNITS-1:0] start_n;
  logic [31:0]          res_n;
  logic                 err_n;
  logic [RES_W-1:0]     sel_res;
  logic                 hit;
  logic                 accept;

  alu_op_decode u_dec (
    .opcode (req_opcode),
    .onehot (dec_oh),
    .legal  (dec_legal)
  );

  assign req_ready = (state == S_IDLE) && !reset;
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready;

  // Only the selected unit's done/result are observed.
  assign hit = |(unit_done & sel);

  always_comb begin
    sel_res = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel[i]) sel_res = sel_res | unit_result[i*RES_W +: RES_W];
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start_n = '0;
    res_n   = rsp_result;
    err_n   = rsp_error;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (dec_legal) begin
            state_n = S_ISSUE;
            start_n = dec_oh;
            cnt_n   = '0;
          end else begin
            state_n = S_RESP;
            res_n   = '0;
            err_n   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (hit) begin
          state_n = S_RESP;
          res_n   = sel_res;
          err_n   = 1'b0;
        end else begin
          state_n = S_WAIT;
          cnt_n   = cnt + 8'd1;
        end
      end
      S_WAIT: begin
        if (hit) begin
          state_n = S_RESP;
          res_n   = sel_res;
          err_n   = 1'b0;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          state_n = S_RESP;
          res_n   = '0;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      unit_start <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      unit_start <= start_n;
      rsp_valid  <= (state_n == S_RESP);
      rsp_result <= res_n;
      rsp_error  <= err_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      op_shamt <= '0;
      sel      <= '0;
    end else if (accept) begin
      op_a     <= req_a;
      op_b     <= req_b;
      op_shamt <= req_shamt;
      sel      <= dec_oh;
    end
  end

endmodule
